// File: rtl/alu_pkg.sv
// Shared constants, function codes and stage-tag type for the execute-stage
// operand/write-back wrapper around the registered ALU.
package alu_pkg;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    typedef enum logic [5:0] {
        FUNC_ADD = 6'd0,
        FUNC_SUB = 6'd1,
        FUNC_DIV = 6'd2,
        FUNC_MUL = 6'd3,
        FUNC_SRL = 6'd4,
        FUNC_SLL = 6'd5
    } alu_func_e;

    localparam logic [5:0] FUNC_MAX = 6'd5;

    // Tag that travels alongside an op through the ISS and EX stages.
    typedef struct packed {
        logic          valid;
        logic          legal;
        logic [AW-1:0] rd;
    } stage_tag_t;

    function automatic logic func_legal(input logic [5:0] func);
        return func <= FUNC_MAX;
    endfunction

endpackage

// File: rtl/alu_operand_wb_if.sv
// Decoded-op handshake plus the operand/result bus between the wrapper and
// the registered ALU.
interface alu_operand_wb_if;
    import alu_pkg::*;

    // An op transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready never depends on in_valid, and the op fields must stay stable
    // while in_valid is held waiting for in_ready.
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [AW-1:0] in_rd;
    logic [5:0]    in_func;
    logic [4:0]    in_shamt;

    logic [5:0]    alu_func;
    logic [4:0]    alu_shamt;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_func, in_shamt,
        input  in_ready,
        input  alu_func, alu_shamt, alu_a, alu_b,
        output alu_result
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_func, in_shamt,
        output in_ready,
        output alu_func, alu_shamt, alu_a, alu_b,
        input  alu_result
    );

endinterface

// File: rtl/alu_operand_wb_regfile_2r1w.sv
// General register file: two combinational operand reads, one debug read,
// one synchronous write; r0 always reads as zero.
module regfile_2r1w
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_ra_addr,
    output logic [DW-1:0] o_ra_data,
    input  logic [AW-1:0] i_rb_addr,
    output logic [DW-1:0] o_rb_data,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data  = (i_ra_addr  == '0) ? '0 : r_mem[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == '0) ? '0 : r_mem[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_operand_wb.sv
// Execute-stage wrapper: reads operands (with EX forwarding), feeds the
// registered ALU, tracks destinations through its latency and writes back.
module alu_operand_wb
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_wb_if.slave      bus,
    output logic                 wb_valid,
    output logic [AW-1:0]        wb_rd,
    output logic                 err_illegal,
    output logic [31:0]          retired_count,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data
);

    stage_tag_t    r_iss;
    stage_tag_t    r_ex;
    logic [5:0]    r_alu_func;
    logic [4:0]    r_alu_shamt;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_rd;
    logic          r_err_illegal;
    logic [31:0]   r_retired_count;

    logic          w_stall;
    logic          w_accept;
    logic          w_ex_write;
    logic [DW-1:0] w_rf_a;
    logic [DW-1:0] w_rf_b;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;

    regfile_2r1w u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra_addr  (bus.in_rs),
        .o_ra_data  (w_rf_a),
        .i_rb_addr  (bus.in_rt),
        .o_rb_data  (w_rf_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .i_we       (w_ex_write),
        .i_waddr    (r_ex.rd),
        .i_wdata    (bus.alu_result)
    );

    // The ISS result is not on alu_result until next cycle, so a dependent
    // op must wait one cycle and then picks it up through the EX forward.
    assign w_stall = r_iss.valid && r_iss.legal && (r_iss.rd != '0) &&
                     ((bus.in_rs == r_iss.rd) || (bus.in_rt == r_iss.rd));

    assign bus.in_ready = !rst && !w_stall;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_ex_write   = r_ex.valid && r_ex.legal && (r_ex.rd != '0);

    always_comb begin
        w_op_a = w_rf_a;
        w_op_b = w_rf_b;
        if (bus.in_rs == '0) begin
            w_op_a = '0;
        end else if (w_ex_write && (r_ex.rd == bus.in_rs)) begin
            w_op_a = bus.alu_result;
        end
        if (bus.in_rt == '0) begin
            w_op_b = '0;
        end else if (w_ex_write && (r_ex.rd == bus.in_rt)) begin
            w_op_b = bus.alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss           <= '0;
            r_ex            <= '0;
            r_alu_func      <= '0;
            r_alu_shamt     <= '0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_err_illegal   <= 1'b0;
            r_retired_count <= '0;
        end else begin
            r_ex        <= r_iss;
            r_iss.valid <= w_accept;
            // ALU inputs only move on accept so bubbles leave them untouched.
            if (w_accept) begin
                r_iss.legal <= func_legal(bus.in_func);
                r_iss.rd    <= bus.in_rd;
                r_alu_func  <= bus.in_func;
                r_alu_shamt <= bus.in_shamt;
                r_alu_a     <= w_op_a;
                r_alu_b     <= w_op_b;
            end
            r_wb_valid <= w_ex_write;
            if (w_ex_write) begin
                r_wb_rd <= r_ex.rd;
            end
            r_err_illegal <= r_ex.valid && !r_ex.legal;
            if (r_ex.valid) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    assign bus.alu_func   = r_alu_func;
    assign bus.alu_shamt  = r_alu_shamt;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign wb_valid       = r_wb_valid;
    assign wb_rd          = r_wb_rd;
    assign err_illegal    = r_err_illegal;
    assign retired_count  = r_retired_count;

endmodule

// File: tb/tb_alu_operand_wb.sv
// Bench for alu_operand_wb: registered-ALU stand-in, program-order register
// model with a retirement queue, directed scenarios and a random run.
module tb_alu_operand_wb;
    import alu_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          err_illegal;
    logic [31:0]   retired_count;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    alu_operand_wb_if bus ();

    alu_operand_wb dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .err_illegal   (err_illegal),
        .retired_count (retired_count),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (f)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            6'd3:    return a * b;
            6'd4:    return b >> sh;
            6'd5:    return b << sh;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU stand-in: samples one edge after issue, holds on illegal func.
    always @(posedge clk) begin
        if (rst) begin
            bus.alu_result <= 32'd0;
        end else if (bus.alu_func <= 6'd5) begin
            bus.alu_result <= alu_ref(bus.alu_func, bus.alu_a, bus.alu_b, bus.alu_shamt);
        end
    end

    // Reference model: architectural registers updated in program order at accept,
    // retirement scheduled two edges later.
    typedef struct {
        int         cyc;
        logic [4:0] rd;
        logic       legal;
    } ret_t;

    ret_t        exp_q[$];
    ret_t        ret_e;
    logic [31:0] ref_reg [32];
    logic [31:0] ref_retired;
    int          edge_cnt = 0;
    int          last_acc = -10;
    logic [4:0]  last_rd;
    logic        last_legal;
    logic        mon_on = 1'b0;
    logic        exp_wb_valid;
    logic [4:0]  exp_wb_rd;
    logic        exp_err;
    logic        chk_ops = 1'b0;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [5:0]  exp_func;
    logic [4:0]  exp_sh;
    logic [31:0] ref_v;

    always @(posedge clk) begin
        edge_cnt++;
        chk_ops = 1'b0;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
            ref_retired  = 32'd0;
            exp_wb_valid = 1'b0;
            exp_wb_rd    = 5'd0;
            exp_err      = 1'b0;
            last_acc     = -10;
            mon_on       = 1'b1;
        end else begin
            exp_wb_valid = 1'b0;
            exp_err      = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                ret_e = exp_q.pop_front();
                ref_retired = ref_retired + 32'd1;
                if (ret_e.legal && ret_e.rd != 5'd0) begin
                    exp_wb_valid = 1'b1;
                    exp_wb_rd    = ret_e.rd;
                end
                if (!ret_e.legal) exp_err = 1'b1;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_a    = (bus.in_rs == 5'd0) ? 32'd0 : ref_reg[bus.in_rs];
                exp_b    = (bus.in_rt == 5'd0) ? 32'd0 : ref_reg[bus.in_rt];
                exp_func = bus.in_func;
                exp_sh   = bus.in_shamt;
                ref_v    = alu_ref(exp_func, exp_a, exp_b, exp_sh);
                if (exp_func <= 6'd5 && bus.in_rd != 5'd0) ref_reg[bus.in_rd] = ref_v;
                exp_q.push_back('{cyc: edge_cnt + 2, rd: bus.in_rd, legal: (exp_func <= 6'd5)});
                last_acc   = edge_cnt;
                last_rd    = bus.in_rd;
                last_legal = (exp_func <= 6'd5);
                chk_ops    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (wb_valid !== exp_wb_valid) begin
                failures++;
                $display("FAIL wb_valid got=%0b exp=%0b t=%0t", wb_valid, exp_wb_valid, $time);
            end
            checks++;
            if (wb_rd !== exp_wb_rd) begin
                failures++;
                $display("FAIL wb_rd got=%0d exp=%0d t=%0t", wb_rd, exp_wb_rd, $time);
            end
            checks++;
            if (err_illegal !== exp_err) begin
                failures++;
                $display("FAIL err_illegal got=%0b exp=%0b t=%0t", err_illegal, exp_err, $time);
            end
            checks++;
            if (retired_count !== ref_retired) begin
                failures++;
                $display("FAIL retired_count got=%0d exp=%0d t=%0t", retired_count, ref_retired, $time);
            end
            if (chk_ops) begin
                checks++;
                if (bus.alu_a !== exp_a || bus.alu_b !== exp_b) begin
                    failures++;
                    $display("FAIL alu_operands got=%h/%h exp=%h/%h t=%0t",
                             bus.alu_a, bus.alu_b, exp_a, exp_b, $time);
                end
                checks++;
                if (bus.alu_func !== exp_func || bus.alu_shamt !== exp_sh) begin
                    failures++;
                    $display("FAIL alu_func_shamt got=%0d/%0d exp=%0d/%0d t=%0t",
                             bus.alu_func, bus.alu_shamt, exp_func, exp_sh, $time);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one op and holds it until accepted; returns the stall cycles seen.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] f, input logic [4:0] sh, output int stalls);
        logic exp_rdy;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_func  = f;
        bus.in_shamt = sh;
        stalls = 0;
        forever begin
            @(negedge clk);
            exp_rdy = !(last_acc == edge_cnt && last_legal && last_rd != 5'd0 &&
                        (rs == last_rd || rt == last_rd));
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL in_ready got=%0b exp=%0b rs=%0d rt=%0d t=%0t",
                         bus.in_ready, exp_rdy, rs, rt, $time);
            end
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            if (stalls > 3) begin
                failures++;
                $display("FAIL accept_timeout got=stalled exp=accepted t=%0t", $time);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_rs = '0;
        bus.in_rt = '0;
        bus.in_rd = '0;
        bus.in_func = '0;
        bus.in_shamt = '0;
        dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_func !== 6'd0 || bus.alu_shamt !== 5'd0) begin
            failures++;
            $display("FAIL reset_alu_outs got=%h/%h/%0d/%0d exp=0", bus.alu_a, bus.alu_b, bus.alu_func, bus.alu_shamt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%0b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int s;
        send(5'd0, 5'd0, 5'd3, FUNC_ADD, 5'd0, s);
        send(5'd0, 5'd3, 5'd4, FUNC_SLL, 5'd4, s);
        idle(4);
        dbg_addr = 5'd3;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            failures++;
            $display("FAIL basic_r3 got=%h exp=0", dbg_data);
        end
    endtask

    task automatic test_preload();
        int s;
        send(5'd0, 5'd0, 5'd1, FUNC_DIV, 5'd0, s);
        send(5'd0, 5'd1, 5'd2, FUNC_SUB, 5'd0, s);
        send(5'd0, 5'd2, 5'd3, FUNC_SLL, 5'd2, s);
        send(5'd0, 5'd2, 5'd4, FUNC_SLL, 5'd1, s);
        send(5'd3, 5'd4, 5'd1, FUNC_ADD, 5'd0, s);
        send(5'd1, 5'd2, 5'd1, FUNC_ADD, 5'd0, s);
        send(5'd3, 5'd2, 5'd2, FUNC_ADD, 5'd0, s);
        idle(4);
        dbg_addr = 5'd1;
        #1;
        checks++;
        if (dbg_data !== 32'd7) begin
            failures++;
            $display("FAIL preload_r1 got=%0d exp=7", dbg_data);
        end
        dbg_addr = 5'd2;
        #1;
        checks++;
        if (dbg_data !== 32'd5) begin
            failures++;
            $display("FAIL preload_r2 got=%0d exp=5", dbg_data);
        end
    endtask

    task automatic test_stall();
        int s1, s2;
        send(5'd0, 5'd0, 5'd5, FUNC_ADD, 5'd0, s1);
        send(5'd0, 5'd0, 5'd6, FUNC_ADD, 5'd0, s1);
        idle(3);
        send(5'd1, 5'd2, 5'd5, FUNC_SUB, 5'd0, s1);
        send(5'd5, 5'd1, 5'd6, FUNC_ADD, 5'd0, s2);
        checks++;
        if (s2 !== 1) begin
            failures++;
            $display("FAIL stall_cycles got=%0d exp=1", s2);
        end
        idle(4);
        dbg_addr = 5'd6;
        #1;
        checks++;
        if (dbg_data !== 32'd9) begin
            failures++;
            $display("FAIL stall_r6 got=%0d exp=9", dbg_data);
        end
    endtask

    task automatic test_forward();
        int s;
        send(5'd0, 5'd0, 5'd5, FUNC_ADD, 5'd0, s);
        send(5'd0, 5'd0, 5'd6, FUNC_ADD, 5'd0, s);
        idle(3);
        send(5'd1, 5'd2, 5'd5, FUNC_SUB, 5'd0, s);
        send(5'd1, 5'd1, 5'd7, FUNC_ADD, 5'd0, s);
        send(5'd5, 5'd1, 5'd6, FUNC_ADD, 5'd0, s);
        checks++;
        if (s !== 0) begin
            failures++;
            $display("FAIL forward_stalls got=%0d exp=0", s);
        end
        idle(4);
        dbg_addr = 5'd6;
        #1;
        checks++;
        if (dbg_data !== 32'd9) begin
            failures++;
            $display("FAIL forward_r6 got=%0d exp=9", dbg_data);
        end
        dbg_addr = 5'd7;
        #1;
        checks++;
        if (dbg_data !== 32'd14) begin
            failures++;
            $display("FAIL forward_r7 got=%0d exp=14", dbg_data);
        end
    endtask

    task automatic test_illegal();
        int s;
        logic [31:0] rc0;
        send(5'd1, 5'd0, 5'd8, FUNC_ADD, 5'd0, s);
        idle(3);
        rc0 = retired_count;
        send(5'd1, 5'd2, 5'd8, 6'd7, 5'd0, s);
        send(5'd8, 5'd0, 5'd9, FUNC_ADD, 5'd0, s);
        checks++;
        if (s !== 0) begin
            failures++;
            $display("FAIL illegal_no_stall got=%0d exp=0", s);
        end
        idle(4);
        checks++;
        if (retired_count !== rc0 + 32'd2) begin
            failures++;
            $display("FAIL illegal_retired got=%0d exp=%0d", retired_count, rc0 + 32'd2);
        end
        dbg_addr = 5'd8;
        #1;
        checks++;
        if (dbg_data !== 32'd7) begin
            failures++;
            $display("FAIL illegal_r8 got=%0d exp=7", dbg_data);
        end
        dbg_addr = 5'd9;
        #1;
        checks++;
        if (dbg_data !== 32'd7) begin
            failures++;
            $display("FAIL illegal_r9 got=%0d exp=7", dbg_data);
        end
    endtask

    task automatic test_rd_zero();
        int s;
        send(5'd1, 5'd2, 5'd0, FUNC_ADD, 5'd0, s);
        send(5'd0, 5'd1, 5'd10, FUNC_ADD, 5'd0, s);
        checks++;
        if (s !== 0) begin
            failures++;
            $display("FAIL rd0_no_stall got=%0d exp=0", s);
        end
        idle(4);
        dbg_addr = 5'd0;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            failures++;
            $display("FAIL rd0_r0 got=%0d exp=0", dbg_data);
        end
        dbg_addr = 5'd10;
        #1;
        checks++;
        if (dbg_data !== 32'd7) begin
            failures++;
            $display("FAIL rd0_r10 got=%0d exp=7", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] f;
        for (int n = 0; n < 60; n++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            f  = 6'($urandom_range(0, 7));
            sh = 5'($urandom_range(0, 31));
            send(rs, rt, rd, f, sh, s);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            checks++;
            if (dbg_data !== ref_reg[i]) begin
                failures++;
                $display("FAIL random_reg r%0d got=%h exp=%h", i, dbg_data, ref_reg[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int s;
        send(5'd1, 5'd2, 5'd9, FUNC_MUL, 5'd0, s);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_func !== 6'd0 || bus.alu_shamt !== 5'd0) begin
            failures++;
            $display("FAIL midreset_alu_outs got=%h/%h/%0d/%0d exp=0", bus.alu_a, bus.alu_b, bus.alu_func, bus.alu_shamt);
        end
        @(posedge clk);
        #1;
        idle(4);
        dbg_addr = 5'd9;
        #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_r9 got=%h exp=0", dbg_data);
        end
        checks++;
        if (retired_count !== 32'd0) begin
            failures++;
            $display("FAIL midreset_retired got=%0d exp=0", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preload();
        test_stall();
        test_forward();
        test_illegal();
        test_rd_zero();
        test_back_to_back();
        test_reset_midflight();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_wb.md
Name: alu_operand_wb

Overview:
- Execute-stage wrapper around the registered ALU.
- Holds the 32x32 general register file, accepts decoded R-type ops over a valid/ready handshake, and drives registered operands/func/shamt into the ALU.
- Tracks each op's destination through the ALU's one-cycle latency and writes the ALU result back.
- Forwards the in-flight result and stalls on the one unresolvable RAW hazard.

Parameters:
- NREG, 32, number of architectural registers (r0 hard-wired zero)
- DW, 32, data width
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded op available
- in_ready  out  1  block accepts op this cycle
- in_rs  in  AW  source A register (drives ALU a)
- in_rt  in  AW  source B register (drives ALU b / shift operand)
- in_rd  in  AW  destination register
- in_func  in  6  ALU function code
- in_shamt  in  5  shift amount
- alu_func  out  6  to ALU func
- alu_shamt  out  5  to ALU shiftamt
- alu_a  out  DW  to ALU a
- alu_b  out  DW  to ALU b
- alu_result  in  DW  from ALU o_data
- wb_valid  out  1  write-back occurred this edge (pulse, registered)
- wb_rd  out  AW  register written
- err_illegal  out  1  one-cycle pulse: retiring op had func > 5, write suppressed
- retired_count  out  32  ops retired (legal or illegal), wraps at 2^32
- dbg_addr  in  AW  debug read address
- dbg_data  out  DW  combinational regfile read, r0 returns 0

Behaviour:
- Reset (synchronous, rst=1 at edge): all regs r0..r31 = 0; ISS and EX valid = 0; alu_func/alu_shamt/alu_a/alu_b = 0; wb_valid = 0; wb_rd = 0; err_illegal = 0; retired_count = 0. in_ready = 0 while rst high. In-flight ops are dropped, never written back.
- Pipeline, for an op accepted at edge E0 (in_valid & in_ready):
  - ISS stage: E0 captures operands into alu_a/alu_b, with func, shamt, rd, and illegal = (func > 5).
  - EX stage: the ALU samples at E1; the block moves the ISS tag to EX.
  - alu_result is valid during the E1->E2 cycle.
  - E2: if EX legal and rd != 0, reg[rd] <= alu_result. wb_valid=1 and wb_rd=rd on the cycle after E2 (registered). retired_count increments at E2.
  - Throughput 1 op/cycle, latency 2 edges accept->regfile.
- Operand read at accept, priority:
  1. Address 0 -> 0.
  2. EX valid, EX legal, EX rd == addr -> alu_result (forward; the same edge writes the regfile).
  3. Otherwise reg[addr].
- Stall: in_ready = 0 when ISS valid, ISS legal, ISS rd != 0, and (in_rs == ISS rd or in_rt == ISS rd). Otherwise in_ready = 1.
  - On a stall cycle ISS drains to EX and ISS becomes a bubble (valid=0).
  - ALU inputs hold their last values during the bubble; the bubble carries no write-back.
- in_valid=0: ISS becomes bubble; no effect on regfile.
- Illegal func (6..63): passed to the ALU unchanged (ALU holds output). At E2 no regfile write, wb_valid=0, err_illegal=1 for one cycle, retired_count still increments. Never forwarded, never causes stall.
- rd = 0: retires normally (counted, wb_valid=0, no write); never forwarded.
- Same register as rs and rt, or rs/rt == own rd: no special case; the read sees the prior value.
- Divide-by-zero and overflow: ALU-defined; this block writes whatever alu_result holds.
- dbg_data shows the post-edge regfile; no forwarding on the debug port.

Decomposition:
- Shared package alu_pkg: FUNC_ADD=0, FUNC_SUB=1, FUNC_DIV=2, FUNC_MUL=3, FUNC_SRL=4, FUNC_SLL=5, FUNC_MAX=5, DW, AW, NREG.
- One sub-module: regfile_2r1w, which has:
  - 2 combinational read ports plus the debug read port
  - 1 synchronous write port with write-enable
  - r0 forced to 0
  - synchronous reset clearing all entries
- Hazard/forward logic and stage registers stay in alu_operand_wb.

Test Plan:
- After reset, issue ADD r3=r0+r0, then SLL r4=r3<<4 (r3 via debug preloaded through ops) -> wb_valid pulses with wb_rd=3 then 4; dbg_addr=3 gives 0.
- Preload r1=7, r2=5 (via ADD from chained ops). Back-to-back SUB r5=r1-r2 then ADD r6=r5+r1 -> in_ready=0 for exactly one cycle on the second op; r6=9.
- SUB r5=r1-r2, independent op, then ADD r6=r5+r1 (gap of one) -> no stall, forward from alu_result, r6=9.
- func=7 with rd=8 -> err_illegal one-cycle pulse, r8 unchanged, retired_count +1, next op reading r8 not stalled.
- rd=0 op (ADD r0=r1+r2) -> r0 reads 0 afterwards, no wb_valid, no stall of a following op reading r0.
- Assert rst one edge after accepting MUL r9=r1*r2 -> r9 stays 0, retired_count=0, all outputs zero next cycle.
